// File: rtl/shuffle_buffer_if.sv
// -----------------------------------------------------------------------------
// shuffle_buffer_if
// Purpose : valid/ready bus bundle for the shuffle_buffer input and output
//           streams.
// Signals : in_valid/in_data/in_ready   - producer -> buffer stream
//           out_valid/out_data/out_ready - buffer -> consumer stream
// Modports: master - the environment side (drives in_*, out_ready)
//           slave  - the buffer side (drives in_ready, out_valid, out_data)
// -----------------------------------------------------------------------------
interface shuffle_buffer_if #(
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  in_valid;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_ready;
    logic                  out_valid;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_ready;

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data
    );
endinterface

// File: rtl/shuffle_buffer.sv
// -----------------------------------------------------------------------------
// shuffle_buffer
// Purpose : handshaked reorder buffer. Words accepted on the input stream are
//           held in a 2^DEPTH_BASE2-entry RAM and re-emitted through a
//           registered output stage, in pseudo-random order when
//           SHUFFLE_BUFFER_RANDOM_EN is defined, in strict FIFO order otherwise.
//           The output stage loads only once FILL_THRESHOLD slots are occupied,
//           unless flush is high.
// Macro   : SHUFFLE_BUFFER_RANDOM_EN - LFSR slot selection (undefined: FIFO)
// Ports   : clk   - clock, rising edge
//           rst   - synchronous active-high reset
//           bus   - shuffle_buffer_if.slave (in_* input stream, out_* output)
//           flush - ignore the fill threshold and drain while high
//           count - occupied RAM slots, output register excluded
// -----------------------------------------------------------------------------
module shuffle_buffer #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned DEPTH_BASE2    = 4,
    parameter int unsigned FILL_THRESHOLD = 4,
    parameter logic [15:0] SEED           = 16'hACE1
) (
    input  logic                 clk,
    input  logic                 rst,
    shuffle_buffer_if.slave      bus,
    input  logic                 flush,
    output logic [DEPTH_BASE2:0] count
);
    localparam int unsigned DEPTH    = 1 << DEPTH_BASE2;
    localparam int unsigned AW       = DEPTH_BASE2;
    localparam int unsigned CW       = DEPTH_BASE2 + 1;
    localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;

    // Elaboration-time parameter sanity check.
    if (DEPTH_BASE2 < 1 || DEPTH_BASE2 > 8 || FILL_THRESHOLD < 1 ||
        FILL_THRESHOLD > DEPTH || SEED_EFF == 16'h0000) begin : g_bad_params
        $error("shuffle_buffer: illegal parameter combination");
    end

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [CW-1:0]         r_count;
    logic                  r_out_valid;
    logic [DATA_WIDTH-1:0] r_out_data;

    logic                  w_in_ready;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_out_free;
    logic                  w_load_ok;
    logic                  w_load;
    logic [AW-1:0]         w_wr_idx;
    logic [AW-1:0]         w_rd_idx;

    // Handshake qualifiers, all from registered state (no comb ready path).
    assign w_in_ready = (r_count < CW'(DEPTH));
    assign w_push     = bus.in_valid && w_in_ready;
    assign w_pop      = r_out_valid && bus.out_ready;
    assign w_out_free = !r_out_valid || bus.out_ready;
    assign w_load_ok  = (r_count >= CW'(FILL_THRESHOLD)) || flush;
    assign w_load     = w_out_free && w_load_ok && (r_count != CW'(0));

`ifdef SHUFFLE_BUFFER_RANDOM_EN
    logic [15:0]    r_lfsr;
    logic [DEPTH-1:0] r_occ;
    logic [15:0]    w_lfsr_next;
    logic [DEPTH-1:0] w_occ_next;

    // Galois LFSR, x^16+x^14+x^13+x^11+1, right-shifting form.
    assign w_lfsr_next = {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? 16'hB400 : 16'h0000);

    // Push target: lowest-index free slot.
    always_comb begin
        logic w_found;
        w_wr_idx = '0;
        w_found  = 1'b0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (!w_found && !r_occ[i]) begin
                w_wr_idx = AW'(i);
                w_found  = 1'b1;
            end
        end
    end

    // Load source: first occupied slot at or above the LFSR start, wrapping.
    // Index arithmetic is AW bits wide, so the wrap is implicit.
    always_comb begin
        logic          w_found;
        logic [AW-1:0] w_idx;
        w_rd_idx = '0;
        w_found  = 1'b0;
        w_idx    = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            w_idx = r_lfsr[AW-1:0] + AW'(i);
            if (!w_found && r_occ[w_idx]) begin
                w_rd_idx = w_idx;
                w_found  = 1'b1;
            end
        end
    end

    // Push targets a free slot and load an occupied one, so they never collide.
    always_comb begin
        w_occ_next = r_occ;
        if (w_load) begin
            w_occ_next = w_occ_next & ~(DEPTH'(1) << w_rd_idx);
        end
        if (w_push) begin
            w_occ_next = w_occ_next | (DEPTH'(1) << w_wr_idx);
        end
    end

    // LFSR advances every cycle regardless of traffic.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_lfsr <= SEED_EFF;
            r_occ  <= '0;
        end else begin
            r_lfsr <= w_lfsr_next;
            r_occ  <= w_occ_next;
        end
    end
`else
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;

    assign w_wr_idx = r_wptr;
    assign w_rd_idx = r_rptr;

    // Circular pointers; DEPTH is a power of two so they wrap naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_load) begin
                r_rptr <= r_rptr + AW'(1);
            end
        end
    end
`endif

    // Storage RAM; contents need no reset because occupancy gates every read.
    always_ff @(posedge clk) begin
        if (!rst && w_push) begin
            r_mem[w_wr_idx] <= bus.in_data;
        end
    end

    // Occupancy count and registered output stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count     <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else begin
            case ({w_push, w_load})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            if (w_load) begin
                r_out_valid <= 1'b1;
                r_out_data  <= r_mem[w_rd_idx];
            end else if (w_pop) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign count         = r_count;
endmodule
